// File: rtl/sva_eval_sched_if.sv
// rtl/sva_eval_sched_if.sv - grant/result handshake between the evaluation scheduler and its monitors
// Signals (one bit per monitor):
//   eval_start : one-hot, one-cycle grant pulse from the scheduler
//   eval_done  : monitor finished its evaluation for this grant
//   eval_succ  : result qualifier, assertion passed
//   eval_fail  : result qualifier, assertion failed
// Modports: master = scheduler side, slave = monitor side.
interface sva_eval_sched_if #(
  parameter int NUM_MON = 4
);
  logic [NUM_MON-1:0] eval_start;
  logic [NUM_MON-1:0] eval_done;
  logic [NUM_MON-1:0] eval_succ;
  logic [NUM_MON-1:0] eval_fail;

  modport master (
    output eval_start,
    input  eval_done,
    input  eval_succ,
    input  eval_fail
  );

  modport slave (
    input  eval_start,
    output eval_done,
    output eval_succ,
    output eval_fail
  );
endinterface

// File: rtl/sva_eval_sched.sv
// rtl/sva_eval_sched.sv - round-robin scheduler sharing one evaluation slot among SVA monitors
// Ports:
//   i_sys_clk, i_sys_rst : scheduler clock, asynchronous active-high reset
//   i_gclk, i_grst       : user clock (sampled as data) and its level reset
//   i_mon_en             : per-monitor enable mask, latched at round start
//   i_clr_stats          : synchronous clear of counters and sticky flags
//   bus (master)         : eval_start grants out, eval_done/succ/fail results in
//   o_busy               : round in progress
//   o_round_done         : one-cycle pulse at the end of each round
//   o_pass_cnt           : saturating count of passing results
//   o_fail_cnt           : saturating count of failing results and timeouts
//   o_missed_cnt         : saturating count of dropped gclk edges
//   o_overrun            : sticky, a gclk edge was dropped
//   o_timeout_err        : sticky, a monitor did not answer in time
module sva_eval_sched #(
  parameter int NUM_MON   = 4,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst,
  input  logic                 i_gclk,
  input  logic                 i_grst,
  input  logic [NUM_MON-1:0]   i_mon_en,
  input  logic                 i_clr_stats,
  sva_eval_sched_if.master     bus,
  output logic                 o_busy,
  output logic                 o_round_done,
  output logic [CNT_WIDTH-1:0] o_pass_cnt,
  output logic [CNT_WIDTH-1:0] o_fail_cnt,
  output logic [CNT_WIDTH-1:0] o_missed_cnt,
  output logic                 o_overrun,
  output logic                 o_timeout_err
);

  localparam int PTR_W = (NUM_MON > 1) ? $clog2(NUM_MON) : 1;
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_MON - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_gclk_d0;
  logic                 r_gclk_d1;
  logic                 r_pend;
  logic [NUM_MON-1:0]   r_mask;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     r_gnt;
  logic [TMO_W-1:0]     r_tmo;
  logic [NUM_MON-1:0]   r_start;
  logic                 r_busy;
  logic                 r_round_done;
  logic [CNT_WIDTH-1:0] r_pass;
  logic [CNT_WIDTH-1:0] r_fail;
  logic [CNT_WIDTH-1:0] r_missed;
  logic                 r_overrun;
  logic                 r_timeout;

  logic                 w_tick;
  logic [NUM_MON-1:0]   w_arb_src;
  int                   w_arb_idx;
  logic [PTR_W-1:0]     w_pick;
  logic [NUM_MON-1:0]   w_pick_oh;
  logic                 w_in_wait;
  logic                 w_done_g;
  logic                 w_succ_g;
  logic                 w_fail_g;
  logic                 w_tmo_hit;
  logic                 w_wait_exit;
  logic                 w_pass_inc;
  logic                 w_fail_inc;
  logic                 w_tmo_evt;
  logic                 w_miss;

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_MON) s = s - NUM_MON;
    return s;
  endfunction

  // gclk is plain data here; the extra ~i_grst term suppresses the edge that
  // the still-set d0 flop would otherwise produce in the cycle grst rises.
  assign w_tick = r_gclk_d0 & ~r_gclk_d1 & ~i_grst;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_gclk_d0 <= 1'b0;
      r_gclk_d1 <= 1'b0;
    end else if (i_grst) begin
      r_gclk_d0 <= 1'b0;
      r_gclk_d1 <= 1'b0;
    end else begin
      r_gclk_d0 <= i_gclk;
      r_gclk_d1 <= r_gclk_d0;
    end
  end

  // The grant is picked one cycle early so eval_start can be registered and
  // still be high during ARB. From IDLE the round's mask is the live enable
  // (about to be latched); from WAIT it is the remaining latched mask.
  assign w_arb_src = (r_state == S_IDLE) ? i_mon_en : r_mask;

  // Scan downward so the candidate nearest to rr_ptr is written last and wins.
  always_comb begin
    w_arb_idx = 0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (w_arb_src[wrap_idx(int'(r_rr_ptr), i)]) begin
        w_arb_idx = wrap_idx(int'(r_rr_ptr), i);
      end
    end
    w_pick    = PTR_W'(w_arb_idx);
    w_pick_oh = NUM_MON'(1) << w_pick;
  end

  assign w_in_wait   = (r_state == S_WAIT);
  assign w_done_g    = bus.eval_done[r_gnt];
  assign w_succ_g    = bus.eval_succ[r_gnt];
  assign w_fail_g    = bus.eval_fail[r_gnt];
  assign w_tmo_hit   = (r_tmo == TMO_LAST);
  assign w_wait_exit = w_in_wait & (w_done_g | w_tmo_hit);

  // A real answer on the last allowed cycle takes precedence over the timeout.
  assign w_pass_inc = w_in_wait & w_done_g & w_succ_g;
  assign w_tmo_evt  = w_in_wait & ~w_done_g & w_tmo_hit;
  assign w_fail_inc = (w_in_wait & w_done_g & ~w_succ_g & w_fail_g) | w_tmo_evt;
  assign w_miss     = w_tick & r_pend & (r_state != S_IDLE);

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state      <= S_IDLE;
      r_pend       <= 1'b0;
      r_mask       <= '0;
      r_rr_ptr     <= '0;
      r_gnt        <= '0;
      r_tmo        <= '0;
      r_start      <= '0;
      r_busy       <= 1'b0;
      r_round_done <= 1'b0;
    end else begin
      // An edge arriving while a round runs is remembered once; in IDLE a
      // pending edge is consumed, but a fresh edge in that same cycle re-arms it.
      if (r_state == S_IDLE) begin
        if (w_tick || r_pend) r_pend <= w_tick & r_pend;
      end else if (w_tick) begin
        r_pend <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_tick || r_pend) begin
            r_mask <= i_mon_en;
            r_busy <= 1'b1;
            if (|i_mon_en) begin
              r_state <= S_ARB;
              r_gnt   <= w_pick;
              r_start <= w_pick_oh;
            end else begin
              r_state      <= S_DONE;
              r_round_done <= 1'b1;
            end
          end
        end
        S_ARB: begin
          r_start        <= '0;
          r_mask[r_gnt]  <= 1'b0;
          r_tmo          <= '0;
          r_state        <= S_WAIT;
        end
        S_WAIT: begin
          if (w_wait_exit) begin
            if (|r_mask) begin
              r_state <= S_ARB;
              r_gnt   <= w_pick;
              r_start <= w_pick_oh;
            end else begin
              r_state      <= S_DONE;
              r_round_done <= 1'b1;
            end
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_DONE: begin
          r_round_done <= 1'b0;
          r_busy       <= 1'b0;
          r_rr_ptr     <= (r_rr_ptr == PTR_LAST) ? '0 : r_rr_ptr + 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Statistics: clear has priority over any same-cycle increment.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_pass    <= '0;
      r_fail    <= '0;
      r_missed  <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else if (i_clr_stats) begin
      r_pass    <= '0;
      r_fail    <= '0;
      r_missed  <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_pass_inc && (r_pass != '1)) r_pass <= r_pass + 1'b1;
      if (w_fail_inc && (r_fail != '1)) r_fail <= r_fail + 1'b1;
      if (w_tmo_evt) r_timeout <= 1'b1;
      if (w_miss) begin
        r_overrun <= 1'b1;
        if (r_missed != '1) r_missed <= r_missed + 1'b1;
      end
    end
  end

  assign bus.eval_start = r_start;
  assign o_busy         = r_busy;
  assign o_round_done   = r_round_done;
  assign o_pass_cnt     = r_pass;
  assign o_fail_cnt     = r_fail;
  assign o_missed_cnt   = r_missed;
  assign o_overrun      = r_overrun;
  assign o_timeout_err  = r_timeout;

endmodule
